// File: rtl/multi_timer_pkg.sv
// Shared register map, CTRL layout and helpers for the multi-channel timer.
// Optional build macro: MULTI_TIMER_WATCHDOG_EN (enables CTRL[3] wd_mode storage).
package multi_timer_pkg;

  localparam logic [15:0] CH_STRIDE    = 16'h0010;
  localparam logic [15:0] OFF_CTRL     = 16'h0000;
  localparam logic [15:0] OFF_LOAD     = 16'h0004;
  localparam logic [15:0] OFF_THRES    = 16'h0008;
  localparam logic [15:0] OFF_COUNT    = 16'h000C;
  localparam logic [15:0] OFF_STATUS   = 16'h0100;
  localparam logic [15:0] OFF_IRQ_EN   = 16'h0104;
  localparam logic [15:0] OFF_PRESCALE = 16'h0108;
  localparam logic [15:0] OFF_WD_KICK  = 16'h010C;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_AR  = 1;
  localparam int CTRL_PWM = 2;
  localparam int CTRL_WD  = 3;

  typedef struct packed {
    logic wd_mode;
    logic pwm_en;
    logic auto_reload;
    logic en;
  } ctrl_t;

  // Without the watchdog build, wd_mode is never stored so it reads back as 0.
  function automatic ctrl_t ctrl_from_bits(input logic [3:0] bits);
    ctrl_t c;
    c = bits;
`ifndef MULTI_TIMER_WATCHDOG_EN
    c.wd_mode = 1'b0;
`endif
    return c;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: reloadable down-counter, PWM generator and expiry pulse.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PWM_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_i,
  input  ctrl_t                 ctrl_i,
  input  logic                  en_next_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] load_i,
  input  logic [PWM_WIDTH-1:0]  thres_i,
  output logic [DATA_WIDTH-1:0] count_o,
  output logic                  pwm_o,
  output logic                  expire_o
);

  logic [DATA_WIDTH-1:0] count_q;
  logic [PWM_WIDTH-1:0]  pwm_cnt_q;
  logic                  pwm_q;
  logic                  pwm_run_s;

  // A (re)load in the same cycle takes priority over and suppresses expiry.
  assign expire_o  = ctrl_i.en & en_next_i & ~start_i & tick_i & (count_q == DATA_WIDTH'(1));
  assign pwm_run_s = ctrl_i.en & ctrl_i.pwm_en & en_next_i;
  assign count_o   = count_q;
  assign pwm_o     = pwm_q;

  // Down-counter: cleared while disabled, reloaded on start, decremented on tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (!en_next_i) begin
      count_q <= '0;
    end else if (start_i) begin
      count_q <= load_i;
    end else if (expire_o) begin
      count_q <= (ctrl_i.auto_reload & ~ctrl_i.wd_mode) ? load_i : '0;
    end else if (tick_i && (count_q != '0)) begin
      count_q <= count_q - DATA_WIDTH'(1);
    end
  end

  // PWM counter and registered compare output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
    end else if (!pwm_run_s) begin
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_q <= (pwm_cnt_q >= thres_i);
      if (tick_i) begin
        pwm_cnt_q <= pwm_cnt_q + PWM_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer with shared prescaler, W1C status/irq and bus slave.
// Optional build macro: MULTI_TIMER_WATCHDOG_EN (channel 0 watchdog and WD_KICK).
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    NUM_CH     = 4,
  parameter int                    PWM_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h4000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ready,
  output logic                  error,
  output logic [NUM_CH-1:0]     pwm,
  output logic                  irq,
  output logic                  wd_rst
);

  localparam logic [ADDR_WIDTH-1:0] CH_SPAN = ADDR_WIDTH'(NUM_CH) * ADDR_WIDTH'(CH_STRIDE);

  ctrl_t                 ctrl_q  [NUM_CH];
  logic [DATA_WIDTH-1:0] load_q  [NUM_CH];
  logic [PWM_WIDTH-1:0]  thres_q [NUM_CH];
  logic [DATA_WIDTH-1:0] count_s [NUM_CH];
  logic [NUM_CH-1:0]     status_q, irq_en_q, expire_s;
  logic [NUM_CH-1:0]     ctrl_wr_s, load_wr_s, thres_wr_s, en_next_s, start_s;
  logic [15:0]           prescale_q, psc_cnt_q;
  logic                  tick_s, status_w1c_s, irq_en_wr_s, presc_wr_s, kick_s, err_s;
  logic [DATA_WIDTH-1:0] rd_s;
  logic [ADDR_WIDTH-1:0] off_s;
  logic                  ch_area_s;
  logic [2:0]            ch_idx_s;
  logic [1:0]            ch_reg_s;

  assign off_s     = address - BASE_ADDR;
  assign ch_area_s = (off_s < CH_SPAN) && (off_s[1:0] == 2'b00);
  assign ch_idx_s  = off_s[6:4];
  assign ch_reg_s  = off_s[3:2];
  assign tick_s    = (psc_cnt_q == prescale_q);

  assign rd_data = rd_s;
  assign error   = err_s;
  assign ready   = 1'b1;
  assign irq     = |(status_q & irq_en_q);

  // Address decode: read mux, write strobes and bad-access flag.
  always_comb begin
    rd_s         = '0;
    err_s        = 1'b0;
    ctrl_wr_s    = '0;
    load_wr_s    = '0;
    thres_wr_s   = '0;
    status_w1c_s = 1'b0;
    irq_en_wr_s  = 1'b0;
    presc_wr_s   = 1'b0;
    kick_s       = 1'b0;
    if (rd_en && wr_en) begin
      err_s = 1'b1;
    end else if (rd_en || wr_en) begin
      if (ch_area_s) begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (ch_idx_s == 3'(n)) begin
            case (ch_reg_s)
              2'd0: begin rd_s = DATA_WIDTH'(ctrl_q[n]);  ctrl_wr_s[n]  = wr_en; end
              2'd1: begin rd_s = load_q[n];               load_wr_s[n]  = wr_en; end
              2'd2: begin rd_s = DATA_WIDTH'(thres_q[n]); thres_wr_s[n] = wr_en; end
              default: begin rd_s = count_s[n]; err_s = wr_en; end
            endcase
          end else begin
            err_s = err_s;
          end
        end
      end else begin
        case (off_s)
          ADDR_WIDTH'(OFF_STATUS):   begin rd_s = DATA_WIDTH'(status_q);   status_w1c_s = wr_en; end
          ADDR_WIDTH'(OFF_IRQ_EN):   begin rd_s = DATA_WIDTH'(irq_en_q);   irq_en_wr_s  = wr_en; end
          ADDR_WIDTH'(OFF_PRESCALE): begin rd_s = DATA_WIDTH'(prescale_q); presc_wr_s   = wr_en; end
`ifdef MULTI_TIMER_WATCHDOG_EN
          ADDR_WIDTH'(OFF_WD_KICK):  kick_s = wr_en;
`else
          ADDR_WIDTH'(OFF_WD_KICK):  err_s  = wr_en;
`endif
          default: err_s = 1'b1;
        endcase
      end
      if (wr_en) begin
        rd_s = '0;
      end else begin
        rd_s = rd_s;
      end
    end else begin
      err_s = 1'b0;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    assign en_next_s[n] = ctrl_wr_s[n] ? wr_data[CTRL_EN] : ctrl_q[n].en;
    // Start on enable rising, on LOAD write while running, or on a watchdog kick.
    assign start_s[n] = en_next_s[n] & (~ctrl_q[n].en | load_wr_s[n] |
                                        ((n == 0) & kick_s & ctrl_q[n].wd_mode));

    timer_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .PWM_WIDTH  (PWM_WIDTH)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick_i    (tick_s),
      .ctrl_i    (ctrl_q[n]),
      .en_next_i (en_next_s[n]),
      .start_i   (start_s[n]),
      .load_i    (load_wr_s[n] ? wr_data : load_q[n]),
      .thres_i   (thres_q[n]),
      .count_o   (count_s[n]),
      .pwm_o     (pwm[n]),
      .expire_o  (expire_s[n])
    );
  end

  // Register file, status W1C (set wins), prescaler.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < NUM_CH; n++) begin
        ctrl_q[n]  <= ctrl_from_bits(4'h0);
        load_q[n]  <= '0;
        thres_q[n] <= '0;
      end
      status_q   <= '0;
      irq_en_q   <= '0;
      prescale_q <= 16'h0000;
      psc_cnt_q  <= 16'h0000;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (ctrl_wr_s[n])  ctrl_q[n]  <= ctrl_from_bits(wr_data[3:0]);
        if (load_wr_s[n])  load_q[n]  <= wr_data;
        if (thres_wr_s[n]) thres_q[n] <= wr_data[PWM_WIDTH-1:0];
      end
      status_q <= (status_q & ~(status_w1c_s ? wr_data[NUM_CH-1:0] : {NUM_CH{1'b0}})) | expire_s;
      if (irq_en_wr_s) irq_en_q <= wr_data[NUM_CH-1:0];
      if (presc_wr_s) begin
        prescale_q <= wr_data[15:0];
        psc_cnt_q  <= 16'h0000;
      end else if (tick_s) begin
        psc_cnt_q  <= 16'h0000;
      end else begin
        psc_cnt_q  <= psc_cnt_q + 16'h0001;
      end
    end
  end

`ifdef MULTI_TIMER_WATCHDOG_EN
  logic wd_rst_q;

  // Sticky watchdog request on channel 0 expiry in wd_mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_rst_q <= 1'b0;
    end else if (expire_s[0] && ctrl_q[0].wd_mode) begin
      wd_rst_q <= 1'b1;
    end
  end

  assign wd_rst = wd_rst_q;
`else
  assign wd_rst = 1'b0;
`endif

endmodule

// File: tb/tb_multi_timer.sv
// Randomized and directed bench for multi_timer against a cycle-level reference model.
module tb_multi_timer;
  localparam int          NCH  = 4;
  localparam int          PW   = 8;
  localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef MULTI_TIMER_WATCHDOG_EN
  localparam bit          WD_ON = 1'b1;
`else
  localparam bit          WD_ON = 1'b0;
`endif
  localparam logic [3:0]  CMASK = WD_ON ? 4'hF : 4'h7;

  logic clk = 1'b0, rst = 1'b0, rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] address = 32'h0, wr_data = 32'h0, rd_data;
  logic ready, error, irq, wd_rst;
  logic [NCH-1:0] pwm;

  multi_timer dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .wr_data(wr_data), .rd_data(rd_data), .ready(ready), .error(error),
    .pwm(pwm), .irq(irq), .wd_rst(wd_rst)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  // reference state
  logic [3:0]    m_ctrl  [NCH];
  logic [31:0]   m_load  [NCH];
  logic [PW-1:0] m_thres [NCH];
  logic [31:0]   m_count [NCH];
  int            m_pcnt  [NCH];
  bit            m_pwm   [NCH];
  logic [NCH-1:0] m_status, m_irqen;
  int m_presc, m_psc;
  bit m_wd;

  logic [31:0] obs_rd;
  bit obs_err, obs_irq, obs_wd;
  logic [NCH-1:0] obs_pwm;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < NCH; n++) begin
      m_ctrl[n] = 4'h0; m_load[n] = 32'h0; m_thres[n] = '0; m_count[n] = 32'h0;
      m_pcnt[n] = 0; m_pwm[n] = 1'b0;
    end
    m_status = '0; m_irqen = '0; m_presc = 0; m_psc = 0; m_wd = 1'b0;
  endtask

  // kind: 0 none, 1 ctrl, 2 load, 3 thres, 4 count, 5 status, 6 irq_en, 7 prescale, 8 kick
  task automatic exp_acc(input bit rd, input bit wr, input logic [31:0] a,
                         output logic [31:0] rdat, output bit err, output int kind, output int ch);
    logic [31:0] off;
    rdat = 32'h0; err = 1'b0; kind = 0; ch = 0;
    if (!(rd || wr)) return;
    if (rd && wr) begin err = 1'b1; return; end
    off = a - BASE;
    if (off < 32'(NCH * 16) && off[1:0] == 2'b00) begin
      ch = int'(off[6:4]); kind = 1 + int'(off[3:2]);
    end else begin
      case (off)
        32'h100: kind = 5;
        32'h104: kind = 6;
        32'h108: kind = 7;
        32'h10C: kind = 8;
        default: kind = 0;
      endcase
    end
    case (kind)
      1: rdat = 32'(m_ctrl[ch]);
      2: rdat = m_load[ch];
      3: rdat = 32'(m_thres[ch]);
      4: rdat = m_count[ch];
      5: rdat = 32'(m_status);
      6: rdat = 32'(m_irqen);
      7: rdat = 32'(m_presc);
      default: rdat = 32'h0;
    endcase
    if (kind == 0) err = 1'b1;
    if (wr && kind == 4) err = 1'b1;
    if (wr && kind == 8 && !WD_ON) err = 1'b1;
    if (!rd || err) rdat = 32'h0;
    if (err) kind = 0;
  endtask

  // One clock edge of the reference: prescaler tick, channel rules, then register writes.
  task automatic model_step(input bit we, input int k, input int c, input logic [31:0] d);
    bit tick;
    logic [NCH-1:0] setv;
    tick = (m_psc == m_presc);
    setv = '0;
    for (int n = 0; n < NCH; n++) begin
      logic [3:0] oc, nc;
      logic [31:0] nload;
      bit ldw, kick, restart;
      oc = m_ctrl[n]; nc = oc;
      ldw  = we && k == 2 && c == n;
      kick = we && k == 8 && n == 0 && oc[3];
      if (we && k == 1 && c == n) nc = d[3:0] & CMASK;
      nload = ldw ? d : m_load[n];
      restart = nc[0] && (!oc[0] || ldw || kick);
      if (oc[0] && oc[2] && nc[0]) begin
        m_pwm[n] = (m_pcnt[n] >= int'(m_thres[n]));
        if (tick) m_pcnt[n] = (m_pcnt[n] + 1) % (1 << PW);
      end else begin
        m_pcnt[n] = 0; m_pwm[n] = 1'b0;
      end
      if (!nc[0]) m_count[n] = 32'h0;
      else if (restart) m_count[n] = nload;
      else if (tick && m_count[n] != 0) begin
        if (m_count[n] == 1) begin
          setv[n] = 1'b1;
          if (n == 0 && oc[3]) m_wd = 1'b1;
          m_count[n] = (oc[1] && !oc[3]) ? m_load[n] : 32'h0;
        end else begin
          m_count[n] = m_count[n] - 1;
        end
      end
      m_ctrl[n] = nc;
      m_load[n] = nload;
      if (we && k == 3 && c == n) m_thres[n] = d[PW-1:0];
    end
    if (we && k == 5) m_status = m_status & ~d[NCH-1:0];
    m_status = m_status | setv;
    if (we && k == 6) m_irqen = d[NCH-1:0];
    if (we && k == 7) begin m_presc = int'(d[15:0]); m_psc = 0; end
    else if (tick) m_psc = 0;
    else m_psc = m_psc + 1;
  endtask

  task automatic cyc(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] er; bit ee; int k, c;
    logic [NCH-1:0] ep;
    @(negedge clk);
    for (int n = 0; n < NCH; n++) ep[n] = m_pwm[n];
    obs_pwm = pwm; obs_irq = irq; obs_wd = wd_rst;
    check_eq("pwm", 32'(pwm), 32'(ep));
    check_eq("irq", 32'(irq), 32'(|(m_status & m_irqen)));
    check_eq("wd_rst", 32'(wd_rst), 32'(m_wd));
    check_eq("ready", 32'(ready), 32'h1);
    rd_en = rd; wr_en = wr; address = a; wr_data = d;
    #1;
    exp_acc(rd, wr, a, er, ee, k, c);
    obs_rd = rd_data; obs_err = error;
    if (rd || wr) begin
      check_eq("error", 32'(error), 32'(ee));
      if (rd) check_eq("rd_data", rd_data, er);
    end
    @(posedge clk);
    model_step(wr && !rd && !ee, k, c, d);
    #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d); cyc(1'b0, 1'b1, BASE + off, d); endtask
  task automatic rd(input logic [31:0] off); cyc(1'b1, 1'b0, BASE + off, 32'h0); endtask
  task automatic idle(input int cnt); for (int i = 0; i < cnt; i++) cyc(1'b0, 1'b0, BASE, 32'h0); endtask

  logic [31:0] addrs[$];
  int seq_exp[6] = '{5, 4, 3, 2, 1, 5};
  int hi, found;

  initial begin
    model_reset();
    for (int n = 0; n <= NCH; n++)
      for (int r = 0; r < 4; r++) addrs.push_back(BASE + 32'(n * 16 + r * 4));
    addrs.push_back(BASE + 32'h100); addrs.push_back(BASE + 32'h104);
    addrs.push_back(BASE + 32'h108); addrs.push_back(BASE + 32'h10C);
    addrs.push_back(BASE + 32'h200); addrs.push_back(BASE + 32'h1);
    addrs.push_back(BASE - 32'h4);
    #23 rst = 1'b1;

    foreach (addrs[i]) cyc(1'b1, 1'b0, addrs[i], 32'h0);

    // periodic channel 0
    wr(32'h104, 32'h1); wr(32'h04, 32'd5); wr(32'h00, 32'h3);
    for (int i = 0; i < 6; i++) begin
      rd(32'h0C);
      check_eq("ch0_seq", obs_rd, 32'(seq_exp[i]));
    end
    wr(32'h100, 32'h1);
    check_eq("irq_before_w1c", 32'(obs_irq), 32'h1);
    rd(32'h100);
    check_eq("irq_after_w1c", 32'(obs_irq), 32'h0);

    // W1C in the same cycle as a hardware set
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (m_count[0] == 1) found = 1; else idle(1);
    end
    check_eq("samecyc_found", 32'(found), 32'h1);
    wr(32'h100, 32'h1);
    rd(32'h100);
    check_eq("samecyc_status", 32'(obs_rd[0]), 32'h1);
    wr(32'h00, 32'h0); wr(32'h100, 32'hF);

    // one-shot channel 1 with prescaler
    wr(32'h108, 32'd3); wr(32'h14, 32'd2); wr(32'h10, 32'h1);
    for (int i = 0; i < 30; i++) rd(32'h1C);
    rd(32'h100); check_eq("oneshot_status", obs_rd, 32'h2);
    rd(32'h1C);  check_eq("oneshot_count", obs_rd, 32'h0);
    wr(32'h10, 32'h0); wr(32'h100, 32'hF); wr(32'h108, 32'h0);

    // PWM duty on channel 2
    wr(32'h28, 32'd64); wr(32'h20, 32'h5); idle(4);
    hi = 0;
    for (int i = 0; i < 256; i++) begin idle(1); hi += int'(obs_pwm[2]); end
    check_eq("pwm_duty192", 32'(hi), 32'd192);
    wr(32'h28, 32'd0); idle(3);
    hi = 0;
    for (int i = 0; i < 20; i++) begin idle(1); hi += int'(obs_pwm[2]); end
    check_eq("pwm_thres0", 32'(hi), 32'd20);

    // bad accesses
    wr(32'h0C, 32'h55);       check_eq("wr_count_err", 32'(obs_err), 32'h1);
    rd(32'h200);              check_eq("rd_unmapped_err", 32'(obs_err), 32'h1);
    cyc(1'b1, 1'b1, BASE + 32'h34, 32'h77); check_eq("both_err", 32'(obs_err), 32'h1);
    rd(32'h34);               check_eq("both_nochange", obs_rd, 32'h0);

`ifdef MULTI_TIMER_WATCHDOG_EN
    wr(32'h04, 32'd10); wr(32'h00, 32'h9);
    for (int r = 0; r < 5; r++) begin idle(7); wr(32'h10C, 32'h0); end
    check_eq("wd_kicked", 32'(obs_wd), 32'h0);
    idle(10); check_eq("wd_before", 32'(obs_wd), 32'h0);
    idle(1);  check_eq("wd_fire", 32'(obs_wd), 32'h1);
    wr(32'h00, 32'h0);
`else
    wr(32'h10C, 32'h1); check_eq("wdkick_err", 32'(obs_err), 32'h1);
    check_eq("wd_tied", 32'(obs_wd), 32'h0);
`endif

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int sel; logic [31:0] a, d;
      sel = $urandom_range(0, 99);
      a = addrs[$urandom_range(0, addrs.size() - 1)];
      d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 15));
      if (sel < 40)      cyc(1'b0, 1'b0, a, d);
      else if (sel < 65) cyc(1'b1, 1'b0, a, d);
      else if (sel < 95) cyc(1'b0, 1'b1, a, d);
      else               cyc(1'b1, 1'b1, a, d);
    end

    // asynchronous reset mid-count
    wr(32'h108, 32'h0);
    for (int n = 0; n < NCH; n++) wr(32'(n * 16), 32'h0);
    wr(32'h100, 32'hFF); wr(32'h104, 32'hF);
    wr(32'h14, 32'd1); wr(32'h10, 32'h1);
    wr(32'h28, 32'd0); wr(32'h20, 32'h5);
    wr(32'h04, 32'd7); wr(32'h00, 32'h1);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (m_count[0] == 3) found = 1; else idle(1);
    end
    check_eq("rst_setup", 32'(found), 32'h1);
    @(negedge clk);
    check_eq("pre_rst_irq", 32'(irq), 32'h1);
    check_eq("pre_rst_pwm2", 32'(pwm[2]), 32'h1);
    rd_en = 1'b1; address = BASE + 32'h0C; #1;
    check_eq("pre_rst_count", rd_data, 32'h3);
    rst = 1'b0; #1;
    check_eq("rst_count", rd_data, 32'h0);
    check_eq("rst_pwm", 32'(pwm), 32'h0);
    check_eq("rst_irq", 32'(irq), 32'h0);
    check_eq("rst_wd", 32'(wd_rst), 32'h0);
    address = BASE + 32'h100; #1; check_eq("rst_status", rd_data, 32'h0);
    address = BASE + 32'h04;  #1; check_eq("rst_load", rd_data, 32'h0);
    rd_en = 1'b0;
    model_reset();
    @(posedge clk); #2 rst = 1'b1;
    foreach (addrs[i]) cyc(1'b1, 1'b0, addrs[i], 32'h0);
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
- Parameterised successor to the single-channel timer: NUM_CH independent down-counters, each with auto-reload/one-shot mode and its own PWM output, sharing one prescaler.
- Adds a masked, write-1-to-clear interrupt status register and a single irq line.
- Memory-mapped slave on the same simple rd_en/wr_en/address bus as the other peripherals, behind the AHB slave adapter.

Parameters:
- DATA_WIDTH, 32, bus data width and counter/LOAD width.
- ADDR_WIDTH, 32, bus address width.
- NUM_CH, 4, number of timer channels, 1..8.
- PWM_WIDTH, 8, PWM counter/threshold width, 3..16.
- BASE_ADDR, 32'h4000_0000, block base address.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- rd_en  in  1  read strobe
- wr_en  in  1  write strobe
- address  in  ADDR_WIDTH  byte address
- wr_data  in  DATA_WIDTH  write data
- rd_data  out  DATA_WIDTH  read data (combinational)
- ready  out  1  transfer complete; constant 1
- error  out  1  bad-access flag (combinational)
- pwm  out  NUM_CH  per-channel PWM, registered
- irq  out  1  interrupt, = |(STATUS & IRQ_EN)
- wd_rst  out  1  watchdog reset request (see optional feature)

Behaviour:
- Register map (offset from BASE_ADDR), channel n at n*0x10:
  - CTRL +0x0 RW: [0] en, [1] auto_reload, [2] pwm_en, [3] wd_mode.
  - LOAD +0x4 RW.
  - PWM_THRES +0x8 RW, low PWM_WIDTH bits used.
  - COUNT +0xC RO.
- Global registers:
  - STATUS 0x100, W1C, one bit per channel.
  - IRQ_EN 0x104 RW.
  - PRESCALE 0x108 RW, 16 bits.
  - WD_KICK 0x10C WO.
- Reset values: all registers 0; pwm 0; irq 0; wd_rst 0; prescaler count 0.
- Bus rules:
  - A valid access has exactly one of rd_en/wr_en high.
  - Both strobes high: no effect, error=1.
  - Unmapped address, or write to a RO register: error=1 in the same cycle, no state change.
  - Read of WO or unmapped address returns 0.
  - Writes take effect at the next clock edge. Reads are zero-latency. Unused read bits return 0.
- Prescaler:
  - Free-running counter counts 0..PRESCALE, then wraps.
  - tick asserts for one cycle on wrap, so PRESCALE=0 gives tick every cycle.
  - A write to PRESCALE restarts the counter at 0.
- Channel counter (per channel):
  - en=0: COUNT held at 0, PWM counter 0, pwm=0.
  - A write to LOAD while en=1, or en rising 0->1: COUNT<=LOAD at the next edge, independent of tick.
  - On tick, COUNT>1: COUNT-1.
  - On tick, COUNT==1: STATUS[n] set; COUNT <= auto_reload ? LOAD : 0. The period is therefore LOAD ticks.
  - On tick, COUNT==0: hold (one-shot done).
  - LOAD=0 with auto_reload: COUNT stays 0, status never set.
- STATUS: a hardware set and a W1C clear of the same bit in the same cycle resolve to set.
- PWM (per channel):
  - PWM counter of PWM_WIDTH bits increments on tick while en&pwm_en, wrapping naturally.
  - pwm <= (pwm_cnt >= PWM_THRES).
  - THRES=0 gives constant high once running; duty = (2^PWM_WIDTH - THRES)/2^PWM_WIDTH.
  - pwm_en=0: counter and pwm cleared.
- Reset mid-operation: all state returns to reset values asynchronously. No pending event survives.

Optional Feature:
- Macro: MULTI_TIMER_WATCHDOG_EN.
- With the macro, channel 0 only:
  - When CTRL[3]=1 and en=1, expiry (COUNT reaching 0) sets wd_rst=1, sticky until rst.
  - A write of any value to WD_KICK reloads COUNT<=LOAD; auto_reload is ignored in wd_mode.
- Without the macro:
  - wd_rst is tied 0.
  - CTRL[3] reads 0.
  - A write to WD_KICK flags error.

Decomposition:
- Package multi_timer_pkg:
  - register offset localparams and channel stride 0x10.
  - CTRL bit index constants.
  - typedef struct packed for CTRL.
- Sub-module timer_channel (one counter + PWM + status-set pulse), instantiated NUM_CH times via generate.
- Prescaler, bus decode and STATUS/IRQ logic stay in the top level.

Test Plan:
- PRESCALE=0, ch0 LOAD=5, CTRL=0x3:
  - STATUS[0] sets every 5 cycles.
  - COUNT sequence 5,4,3,2,1,5.
  - With IRQ_EN[0]=1, irq rises with STATUS; W1C 0x1 drops it.
- PRESCALE=3, ch1 LOAD=2, one-shot:
  - COUNT decrements every 4 cycles.
  - STATUS[1] sets once.
  - COUNT stays 0 thereafter.
- PWM_WIDTH=8, ch2 THRES=64, CTRL=0x5: pwm high exactly 192 of every 256 ticks; THRES=0 gives pwm constant 1.
- Same-cycle STATUS hardware set and W1C of that bit -> bit reads 1 afterward.
- Bad accesses, each with error=1 and no state change:
  - Write COUNT.
  - Read 0x200.
  - rd_en&wr_en together.
- Assert rst mid-count with ch0 COUNT=3 -> all registers, pwm, irq immediately 0.
- With MULTI_TIMER_WATCHDOG_EN, ch0 LOAD=10, CTRL=0x9:
  - Kicks every 8 cycles keep wd_rst=0.
  - Stopping kicks -> wd_rst=1, 10 cycles after the last kick.
